// File: rtl/d_ff_pkg.sv
// Shared constants and types for the d_ff register slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: default width, default reset value, and a data type sized by the default width.
package d_ff_pkg;

    localparam int D_FF_WIDTH_DFLT = 1;

    localparam logic [D_FF_WIDTH_DFLT-1:0] D_FF_RST_VAL_DFLT = '0;

    typedef logic [D_FF_WIDTH_DFLT-1:0] d_ff_data_t;

endpackage : d_ff_pkg

// File: rtl/d_ff_if.sv
// Data/result bundle between a d_ff and whoever drives it.
// Latency: n/a (wires only).
// Backpressure: none; q/qbar are always valid once reset or a capture has occurred.
// Signals: d (to register), q/qbar (from register), en (only when D_FF_CLKEN_EN is defined).
// Modports: master = driver side, slave = register side.
interface d_ff_if
    import d_ff_pkg::*;
#(
    parameter int WIDTH = D_FF_WIDTH_DFLT
);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;

`ifdef D_FF_CLKEN_EN
    logic             en;

    modport master (output d, output en, input q, input qbar);
    modport slave  (input d, input en, output q, output qbar);
`else
    modport master (output d, input q, input qbar);
    modport slave  (input d, output q, output qbar);
`endif

endinterface : d_ff_if

// File: rtl/d_ff_bit.sv
// Single-bit rising-edge flop with asynchronous active-high reset to a per-bit value.
// Latency: one clk edge from d to q.
// Backpressure: none; with D_FF_CLKEN_EN defined, en low holds q (rst still wins).
// Ports: clk, rst, [en], d -> q.
module d_ff_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
`ifdef D_FF_CLKEN_EN
    input  logic en,
`endif
    input  logic d,
    output logic q
);

`ifdef D_FF_CLKEN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end
`endif

endmodule : d_ff_bit

// File: rtl/d_ff.sv
// WIDTH-bit D register with complemented output, built from per-bit flops.
// Latency: one clk edge from d to q; qbar follows q combinationally with no skew.
// Backpressure: none; optional clock enable via macro D_FF_CLKEN_EN (en low holds q).
// Ports: clk, rst (async, active-high, loads RST_VAL), bus (d_ff_if.slave: d, q, qbar, [en]).
// WIDTH is meant for 1..64.
module d_ff
    import d_ff_pkg::*;
#(
    parameter int               WIDTH   = D_FF_WIDTH_DFLT,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(D_FF_RST_VAL_DFLT)
) (
    input  logic   clk,
    input  logic   rst,
    d_ff_if.slave  bus
);

    logic [WIDTH-1:0] q_r;

    // One flop per bit keeps every lane fully independent; the reset value
    // is sliced so each bit can come out of reset high or low.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_ff_bit #(
            .RST_VAL (RST_VAL[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
`ifdef D_FF_CLKEN_EN
            .en  (bus.en),
`endif
            .d   (bus.d[i]),
            .q   (q_r[i])
        );
    end

    // qbar carries no state of its own, so it can never disagree with q.
    assign bus.q    = q_r;
    assign bus.qbar = ~q_r;

endmodule : d_ff

// File: tb/tb_d_ff.sv
module tb_d_ff;
    import d_ff_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Rising edges at t = 10, 30, 50, ...
    always #10 clk = ~clk;

    d_ff_if #(.WIDTH(1)) bus1 ();

    d_ff #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

`ifdef D_FF_CLKEN_EN
    logic rst8 = 1'b0;

    d_ff_if #(.WIDTH(8)) bus8 ();

    d_ff #(
        .WIDTH   (8),
        .RST_VAL (8'hA5)
    ) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (bus8.slave)
    );
`endif

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [7:0]  exp_q[$];
    string       tag_q[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_push(input string tag, input logic [7:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    // Pops one expectation and checks both q and qbar; mask selects live bits.
    task automatic sb_pop(input logic [7:0] q_obs, input logic [7:0] qbar_obs,
                          input logic [7:0] mask);
        logic [7:0] e;
        string      t;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_empty: got no expectation, want one queued (t=%0t)", $time);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, "_q"},    q_obs & mask,    e & mask);
            chk({t, "_qbar"}, qbar_obs & mask, ~e & mask);
        end
    endtask

    task automatic pop1();
        sb_pop({7'b0, bus1.q}, {7'b0, bus1.qbar}, 8'h01);
    endtask

    task automatic at(input int t);
        if ($time < t) #(t - $time);
    endtask

    initial begin
        logic b;

        bus1.d = 1'b1;
`ifdef D_FF_CLKEN_EN
        bus1.en = 1'b1;
        bus8.d  = 8'h00;
        bus8.en = 1'b0;
`endif
        // Capture straight from power-up at the t=10 edge.
        sb_push("pwrup", 8'h01);
        at(11); pop1();

        // Asynchronous reset between edges: no clock needed.
        at(15); rst = 1'b1;
        sb_push("arst", 8'h00);
        at(16); pop1();
        at(23); rst = 1'b0;
        sb_push("arst_hold", 8'h00);
        at(24); pop1();

        // Normal capture.
        at(29); bus1.d = 1'b0;
        sb_push("cap0", 8'h00);
        at(31); pop1();
        sb_push("hold0", 8'h00);
        at(51); pop1();
        at(59); bus1.d = 1'b1;
        sb_push("cap1", 8'h01);
        at(71); pop1();
        at(79); bus1.d = 1'b0;
        sb_push("cap0b", 8'h00);
        at(91); pop1();

        // Glitch on d that does not span an edge.
        at(95); bus1.d = 1'b1;
        sb_push("glitch", 8'h00);
        at(96); pop1();
        at(97); bus1.d = 1'b0;
        sb_push("glitch_edge", 8'h00);
        at(111); pop1();

        // Reset held across an edge with d=1, then released on an edge.
        at(115); bus1.d = 1'b1; rst = 1'b1;
        sb_push("rst_on", 8'h00);
        at(116); pop1();
        sb_push("rst_edge", 8'h00);
        at(131); pop1();
        at(149);
        @(posedge clk);
        // Release after the flop has sampled this edge with rst still high.
        rst <= 1'b0;
        sb_push("rst_rel_edge", 8'h00);
        at(151); pop1();
        sb_push("first_cap", 8'h01);
        at(171); pop1();

        // Reset mid-operation discards the captured 1 at once.
        at(175); rst = 1'b1;
        sb_push("mid_rst", 8'h00);
        at(176); pop1();
        at(180); rst = 1'b0;
        sb_push("after_rst", 8'h01);
        at(191); pop1();

        // Random data, one capture per edge.
        for (int i = 0; i < 16; i++) begin
            at(195 + 20 * i);
            b = 1'($urandom_range(0, 1));
            bus1.d = b;
            sb_push("rand", {7'b0, b});
            at(211 + 20 * i); sb_pop({7'b0, bus1.q}, {7'b0, bus1.qbar}, 8'h01);
        end

`ifdef D_FF_CLKEN_EN
        at(605); rst8 = 1'b1; bus8.en = 1'b0; bus8.d = 8'h3C;
        sb_push("en_rst", 8'hA5);
        at(606); sb_pop(bus8.q, bus8.qbar, 8'hFF);
        at(615); rst8 = 1'b0;
        sb_push("en_low", 8'hA5);
        at(631); sb_pop(bus8.q, bus8.qbar, 8'hFF);
        at(635); bus8.en = 1'b1;
        sb_push("en_high", 8'h3C);
        at(651); sb_pop(bus8.q, bus8.qbar, 8'hFF);
        at(655); rst8 = 1'b1;
        sb_push("en_rst_async", 8'hA5);
        at(656); sb_pop(bus8.q, bus8.qbar, 8'hFF);
        sb_push("en_rst_edge", 8'hA5);
        at(671); sb_pop(bus8.q, bus8.qbar, 8'hFF);
        at(675); rst8 = 1'b0;
`endif

        at(700);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL sb_leftover: got %0d queued, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_d_ff
